// File: rtl/dnn2ami_rd_path.sv
// Read sequencer: splits DNNWeaver macro reads into 8-byte AMI reads and steers
// the in-order AMI responses into the requesting PU's input buffer.
package dnn2ami_pkg;
    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] data;
        logic [31:0] size;
    } AMIRequest;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [31:0] size;
    } AMIResponse;
endpackage

module dnn2ami_rd_path
    import dnn2ami_pkg::*;
#(
    parameter int NUM_PU          = 2,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int TX_SIZE_WIDTH   = 10,
    parameter int NUM_PU_W        = $clog2(NUM_PU) + 1,
    parameter int LOG_MACRO_Q     = 3,
    parameter int LOG_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_req,
    input  logic [NUM_PU_W-1:0]          rd_pu_id,
    input  logic [TX_SIZE_WIDTH-1:0]     rd_req_size,
    input  logic [AXI_ADDR_WIDTH-1:0]    rd_addr,
    output logic                         rd_ready,
    output logic                         rd_done,
    output logic                         reqValid,
    output AMIRequest                    reqOut,
    input  logic                         reqOut_grant,
    input  logic                         respValid,
    input  AMIResponse                   respIn,
    output logic                         respGrant,
    input  logic [NUM_PU-1:0]            inbuf_full,
    output logic [NUM_PU*AXI_DATA_WIDTH-1:0] data_to_inbuf,
    output logic [NUM_PU-1:0]            inbuf_push,
    output logic                         rd_err
);
    localparam int MQ_DEPTH  = 1 << LOG_MACRO_Q;
    localparam int TAG_DEPTH = 1 << LOG_OUTSTANDING;

    typedef enum logic {S_IDLE, S_ISSUE} seq_state_t;

    // Macro request queue
    logic [AXI_ADDR_WIDTH-1:0] mq_addr [MQ_DEPTH];
    logic [TX_SIZE_WIDTH-1:0]  mq_size [MQ_DEPTH];
    logic [NUM_PU_W-1:0]       mq_pu   [MQ_DEPTH];
    logic [LOG_MACRO_Q-1:0]    mq_wr, mq_rd;
    logic [LOG_MACRO_Q:0]      mq_cnt;
    logic                      mq_full, mq_empty, mq_push, mq_pop;

    // Tag FIFO: one entry per AMI read in flight
    logic [NUM_PU_W-1:0]        tag_pu   [TAG_DEPTH];
    logic                       tag_last [TAG_DEPTH];
    logic [LOG_OUTSTANDING-1:0] tag_wr, tag_rd;
    logic [LOG_OUTSTANDING:0]   tag_cnt;
    logic                       tag_full, tag_empty, tag_push, tag_pop;

    seq_state_t                state, state_nx;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [TX_SIZE_WIDTH-1:0]  beats_left;
    logic [NUM_PU_W-1:0]       cur_pu;
    logic                      cur_last;
    logic                      head_full;
    logic                      unused_resp;

    assign mq_full   = mq_cnt[LOG_MACRO_Q];
    assign mq_empty  = (mq_cnt == '0);
    assign mq_push   = rd_req && !mq_full && (rd_req_size != '0);
    assign rd_ready  = !mq_full;
    assign tag_full  = tag_cnt[LOG_OUTSTANDING];
    assign tag_empty = (tag_cnt == '0);
    assign cur_last  = (beats_left == TX_SIZE_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (mq_push) begin
            mq_addr[mq_wr] <= rd_addr;
            mq_size[mq_wr] <= rd_req_size;
            mq_pu[mq_wr]   <= rd_pu_id;
        end
        if (tag_push) begin
            tag_pu[tag_wr]   <= cur_pu;
            tag_last[tag_wr] <= cur_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_wr   <= '0;
            mq_rd   <= '0;
            mq_cnt  <= '0;
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
        end else begin
            if (mq_push) mq_wr <= mq_wr + 1'b1;
            if (mq_pop) mq_rd <= mq_rd + 1'b1;
            mq_cnt <= mq_cnt + {{LOG_MACRO_Q{1'b0}}, mq_push} - {{LOG_MACRO_Q{1'b0}}, mq_pop};
            if (tag_push) tag_wr <= tag_wr + 1'b1;
            if (tag_pop) tag_rd <= tag_rd + 1'b1;
            tag_cnt <= tag_cnt + {{LOG_OUTSTANDING{1'b0}}, tag_push}
                               - {{LOG_OUTSTANDING{1'b0}}, tag_pop};
        end
    end

    always_comb begin
        state_nx = state;
        mq_pop   = 1'b0;
        reqValid = 1'b0;
        tag_push = 1'b0;
        case (state)
            S_IDLE: begin
                if (!mq_empty) begin
                    mq_pop   = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                reqValid = !tag_full;
                tag_push = reqValid && reqOut_grant;
                if (tag_push && cur_last) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            cur_pu     <= '0;
        end else begin
            state <= state_nx;
            if (mq_pop) begin
                cur_addr   <= mq_addr[mq_rd];
                beats_left <= mq_size[mq_rd];
                cur_pu     <= mq_pu[mq_rd];
            end else if (tag_push) begin
                cur_addr   <= cur_addr + AXI_ADDR_WIDTH'(8);
                beats_left <= beats_left - TX_SIZE_WIDTH'(1);
            end
        end
    end

    always_comb begin
        reqOut         = '0;
        reqOut.valid   = reqValid;
        reqOut.isWrite = 1'b0;
        reqOut.addr    = 64'(cur_addr);
        reqOut.size    = 32'd8;
    end

    // A response with no tag outstanding is granted to drain it, but goes nowhere.
    always_comb begin
        head_full  = 1'b0;
        inbuf_push = '0;
        for (int p = 0; p < NUM_PU; p++) begin
            if (tag_pu[tag_rd] == p[NUM_PU_W-1:0]) head_full = inbuf_full[p];
        end
        tag_pop   = respValid && !tag_empty && !head_full;
        respGrant = respValid && (tag_empty || !head_full);
        for (int p = 0; p < NUM_PU; p++) begin
            if (tag_pop && (tag_pu[tag_rd] == p[NUM_PU_W-1:0])) inbuf_push[p] = 1'b1;
        end
    end

    assign data_to_inbuf = {NUM_PU{respIn.data[AXI_DATA_WIDTH-1:0]}};
    assign unused_resp   = ^{respIn.valid, respIn.size};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_done <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            rd_done <= tag_pop && tag_last[tag_rd];
            rd_err  <= rd_err || (respValid && tag_empty);
        end
    end
endmodule

// File: tb/tb_dnn2ami_rd_path.sv
// Randomized scoreboard bench for dnn2ami_rd_path with an in-bench AMI memory
// responder and a transaction-level model of the expected request/push streams.
module tb_dnn2ami_rd_path;
    import dnn2ami_pkg::*;

    localparam int NUM_PU = 2;
    localparam int AW     = 32;
    localparam int DW     = 64;
    localparam int SW     = 10;
    localparam int PW     = 2;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   rd_req;
    logic [PW-1:0]          rd_pu_id;
    logic [SW-1:0]          rd_req_size;
    logic [AW-1:0]          rd_addr;
    logic                   rd_ready;
    logic                   rd_done;
    logic                   reqValid;
    AMIRequest              reqOut;
    logic                   reqOut_grant;
    logic                   respValid;
    AMIResponse             respIn;
    logic                   respGrant;
    logic [NUM_PU-1:0]      inbuf_full;
    logic [NUM_PU*DW-1:0]   data_to_inbuf;
    logic [NUM_PU-1:0]      inbuf_push;
    logic                   rd_err;

    dnn2ami_rd_path dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_pu_id(rd_pu_id), .rd_req_size(rd_req_size), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_done(rd_done),
        .reqValid(reqValid), .reqOut(reqOut), .reqOut_grant(reqOut_grant),
        .respValid(respValid), .respIn(respIn), .respGrant(respGrant),
        .inbuf_full(inbuf_full), .data_to_inbuf(data_to_inbuf), .inbuf_push(inbuf_push),
        .rd_err(rd_err)
    );

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    // scoreboard: expected request addresses and expected PU pushes, in order
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [PW-1:0] exp_pu_q[$];
    bit            exp_last_q[$];
    bit            exp_done = 1'b0;
    bit            exp_err  = 1'b0;

    // AMI memory model: reads granted and not yet answered
    logic [AW-1:0] ami_a[$];
    int            ami_t[$];

    int grant_cnt = 0, accept_cnt = 0, done_cnt = 0, req_seen_cnt = 0;

    int                grant_mode = 1;   // 0 never, 1 always, 2 random
    bit                resp_en    = 1'b1;
    bit                err_inject = 1'b0;
    bit                full_rand  = 1'b0;
    logic [NUM_PU-1:0] full_force = '0;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {a ^ 32'h5A5A_A5A5, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // environment: grant, buffer-full and response driving
    always @(posedge clk) begin
        cyc++;
        #1;
        case (grant_mode)
            0:       reqOut_grant = 1'b0;
            1:       reqOut_grant = 1'b1;
            default: reqOut_grant = ($urandom_range(0, 3) != 0);
        endcase
        if (full_rand)
            inbuf_full = ($urandom_range(0, 4) == 0) ? NUM_PU'($urandom_range(1, 3)) : '0;
        else
            inbuf_full = full_force;
        respIn = '0;
        if (err_inject) begin
            respValid    = 1'b1;
            respIn.valid = 1'b1;
            respIn.data  = 64'hBAD0_0000_DEAD_BEEF;
        end else if (resp_en && ami_a.size() > 0 && (cyc - ami_t[0]) >= 3) begin
            respValid    = 1'b1;
            respIn.valid = 1'b1;
            respIn.data  = mem_data(ami_a[0]);
            respIn.size  = 32'd8;
        end else begin
            respValid = 1'b0;
        end
    end

    // monitor: samples mid-cycle, just ahead of the edge the handshakes complete on
    always @(negedge clk) begin
        if (rst_n) begin
            logic [AW-1:0]     ea;
            logic [PW-1:0]     pu;
            logic [DW-1:0]     d;
            bit                l;
            logic [NUM_PU-1:0] ev;
            bit                eg;
            int                sz;

            check("rd_done", rd_done, exp_done);
            exp_done = 1'b0;
            check("rd_err", rd_err, exp_err);
            if (rd_done) done_cnt++;

            if (reqValid) begin
                req_seen_cnt++;
                if (reqOut_grant) begin
                    grant_cnt++;
                    if (exp_addr_q.size() == 0) flag_fail("req_unexpected");
                    else begin
                        ea = exp_addr_q.pop_front();
                        check("req_addr", reqOut.addr, {32'b0, ea});
                    end
                    check("req_ctl", {reqOut.valid, reqOut.isWrite}, 2'b10);
                    check("req_size", reqOut.size, 32'd8);
                    check("req_data", reqOut.data, 64'd0);
                    ami_a.push_back(reqOut.addr[AW-1:0]);
                    ami_t.push_back(cyc);
                end
            end

            eg = 1'b0;
            if (respValid) begin
                if (ami_a.size() == 0) eg = 1'b1;
                else if (exp_pu_q.size() > 0) eg = !inbuf_full[exp_pu_q[0]];
                else eg = 1'b1;
            end
            check("resp_grant", respGrant, eg);

            if (respValid && respGrant) begin
                if (ami_a.size() == 0) begin
                    check("err_nopush", inbuf_push, 0);
                    exp_err = 1'b1;
                end else begin
                    void'(ami_a.pop_front());
                    void'(ami_t.pop_front());
                    if (exp_data_q.size() == 0) flag_fail("push_unexpected");
                    else begin
                        pu = exp_pu_q.pop_front();
                        d  = exp_data_q.pop_front();
                        l  = exp_last_q.pop_front();
                        ev = '0;
                        ev[pu] = 1'b1;
                        check("push_vec", inbuf_push, ev);
                        check("push_data", data_to_inbuf[int'(pu)*DW +: DW], d);
                        if (l) exp_done = 1'b1;
                    end
                end
            end else begin
                check("push_idle", inbuf_push, 0);
            end

            if (rd_req && rd_ready && rd_req_size != 0) begin
                accept_cnt++;
                sz = int'(rd_req_size);
                for (int i = 0; i < sz; i++) begin
                    ea = rd_addr + AW'(i * 8);
                    exp_addr_q.push_back(ea);
                    exp_data_q.push_back(mem_data(ea));
                    exp_pu_q.push_back(rd_pu_id);
                    exp_last_q.push_back(i == sz - 1);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int pu, input int size, input logic [AW-1:0] addr);
        rd_req      = 1'b1;
        rd_pu_id    = PW'(pu);
        rd_req_size = SW'(size);
        rd_addr     = addr;
        step();
        rd_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_addr_q.size() != 0 || exp_data_q.size() != 0 || ami_a.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) flag_fail({"drain_", name});
        else tests++;
        repeat (3) step();
    endtask

    task automatic check_reset(input string name);
        check({name, "_rd_ready"}, rd_ready, 1);
        check({name, "_reqValid"}, reqValid, 0);
        check({name, "_respGrant"}, respGrant, 0);
        check({name, "_inbuf_push"}, inbuf_push, 0);
        check({name, "_rd_done"}, rd_done, 0);
        check({name, "_rd_err"}, rd_err, 0);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout");
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        int g0, a0, d0, r0, n;
        bit seen;
        rd_req = 1'b0; rd_pu_id = '0; rd_req_size = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset("rst_init");
        rst_n = 1'b1;
        repeat (2) step();

        // single request, first request two cycles after acceptance
        grant_mode = 1; resp_en = 1'b1;
        d0 = done_cnt;
        issue(1, 4, 32'h0000_1000);
        @(negedge clk); check("lat_n1", reqValid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("lat_burst", reqValid, 1);
        end
        @(negedge clk); check("lat_after", reqValid, 0);
        #2;
        drain("single");
        check("single_done_cnt", done_cnt - d0, 1);

        // outstanding limit
        resp_en = 1'b0;
        g0 = grant_cnt;
        issue(0, 20, 32'h0000_2000);
        repeat (30) step();
        check("outst_grants", grant_cnt - g0, 16);
        @(negedge clk); check("outst_stall", reqValid, 0);
        resp_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (respValid && respGrant) seen = 1'b1;
        end
        resp_en = 1'b0;
        if (!seen) flag_fail("outst_no_resp");
        @(negedge clk); check("outst_reassert", reqValid, 1);
        #2;
        resp_en = 1'b1;
        drain("outst");

        // backpressure from PU0 holds all responses
        full_force = 2'b01;
        d0 = done_cnt;
        issue(0, 2, 32'h0000_4000);
        issue(1, 2, 32'h0000_5000);
        repeat (12) step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_grant", respGrant, 0);
            check("bp_hold_push", inbuf_push, 0);
        end
        #2;
        full_force = '0;
        drain("bp");
        check("bp_done_cnt", done_cnt - d0, 2);

        // macro queue full while the sequencer is stuck
        grant_mode = 0;
        issue(0, 1, 32'h0000_6000);
        repeat (3) step();
        a0 = accept_cnt;
        for (int i = 0; i < 9; i++) begin
            rd_req      = 1'b1;
            rd_pu_id    = PW'($urandom_range(0, 1));
            rd_req_size = SW'($urandom_range(1, 3));
            rd_addr     = 32'h0001_0000 + AW'(i * 32'h100);
            step();
        end
        rd_req = 1'b0;
        check("qfull_accepted", accept_cnt - a0, 8);
        @(negedge clk); check("qfull_rd_ready", rd_ready, 0);
        #2;
        grant_mode = 1;
        drain("qfull");

        // zero-size request is dropped
        r0 = req_seen_cnt; d0 = done_cnt;
        issue(1, 0, 32'h0000_7000);
        repeat (10) step();
        check("zero_no_req", req_seen_cnt - r0, 0);
        check("zero_no_done", done_cnt - d0, 0);

        // randomized traffic including address wrap
        grant_mode = 2; full_rand = 1'b1;
        a0 = accept_cnt; d0 = done_cnt;
        for (int k = 0; k < 60; k++) begin
            rd_req      = ($urandom_range(0, 1) == 1);
            rd_pu_id    = PW'($urandom_range(0, 1));
            rd_req_size = ($urandom_range(0, 9) == 0) ? SW'(0) : SW'($urandom_range(1, 12));
            rd_addr     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 + AW'(k * 8))
                                                      : ($urandom() & 32'hFFFF_FFF8);
            step();
        end
        rd_req = 1'b0;
        full_rand = 1'b0;
        grant_mode = 1;
        drain("random");
        check("rand_done_cnt", done_cnt - d0, accept_cnt - a0);

        // stray response sets the sticky error
        err_inject = 1'b1;
        step();
        err_inject = 1'b0;
        repeat (4) step();
        check("err_sticky", rd_err, 1);

        // reset in the middle of issuing
        resp_en = 1'b0;
        issue(0, 20, 32'h0000_8000);
        repeat (4) step();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        exp_addr_q.delete(); exp_data_q.delete(); exp_pu_q.delete(); exp_last_q.delete();
        ami_a.delete(); ami_t.delete();
        exp_err = 1'b0; exp_done = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        check("rst_stays_idle", reqValid, 0);

        // late response after reset is an error
        err_inject = 1'b1;
        step();
        err_inject = 1'b0;
        n = 0;
        while (!rd_err && n < 10) begin step(); n++; end
        check("err_after_reset", rd_err, 1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/dnn2ami_rd_path.md
Name: dnn2ami_rd_path

Overview:
- Read-direction companion of the DNNWeaver-to-AMI write sequencer.
- Accepts macro read requests from the DNNWeaver memory controller: PU id, byte address, beat count.
- Splits each into 8-byte AMI read requests.
- Returns in-order AMI read responses into the requesting PU's input buffer, with a done pulse per completed macro request.

Parameters:
NUM_PU, 2, number of processing units
AXI_ADDR_WIDTH, 32, macro request address width
AXI_DATA_WIDTH, 64, beat width; one beat per AMI request
TX_SIZE_WIDTH, 10, width of beat count per macro request
NUM_PU_W, $clog2(NUM_PU)+1, PU id width
LOG_MACRO_Q, 3, log2 depth of macro read queue
LOG_OUTSTANDING, 4, log2 max AMI reads in flight (tag FIFO depth)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_req  in  1  macro read request strobe
rd_pu_id  in  NUM_PU_W  destination PU
rd_req_size  in  TX_SIZE_WIDTH  beats (8 B each) to read
rd_addr  in  AXI_ADDR_WIDTH  start byte address, 8-B aligned
rd_ready  out  1  macro queue can accept a request
rd_done  out  1  one-cycle pulse when the final beat of a macro request has been pushed to its PU
reqValid  out  1  AMI request valid
reqOut  out  AMIRequest  AMI request payload
reqOut_grant  in  1  AMI request accepted this cycle
respValid  in  1  AMI read response valid
respIn  in  AMIResponse  response payload (data field used)
respGrant  out  1  response consumed this cycle
inbuf_full  in  NUM_PU  per-PU input buffer full
data_to_inbuf  out  NUM_PU*AXI_DATA_WIDTH  response data replicated to every PU slice
inbuf_push  out  NUM_PU  per-PU write strobe
rd_err  out  1  sticky: response received with no read outstanding

Behaviour:
- Reset (async assert, sync release): macro queue and tag FIFO emptied; sequencer IDLE; address, count and PU id zero.
- Reset values: rd_ready=1, reqValid=0, respGrant=0, inbuf_push=0, rd_done=0, rd_err=0.
- Reset mid-operation abandons all in-flight reads. Responses arriving afterwards set rd_err.
- Macro enqueue: rd_req && rd_ready && rd_req_size!=0. rd_ready = !macroQ_full.
- Zero-size requests are silently dropped: no AMI traffic, no rd_done.
- Sequencer IDLE:
  - if macro queue non-empty: dequeue; load cur_addr, beats_left, cur_pu; go to ISSUE on the next edge.
- Sequencer ISSUE:
  - reqValid = !tagQ_full.
  - reqOut = {valid:reqValid, isWrite:0, addr:{32'b0,cur_addr}, data:0, size:8}.
  - On reqValid && reqOut_grant: push {cur_pu, last=(beats_left==1)} into tag FIFO; cur_addr += 8; beats_left -= 1.
  - When the last beat is granted: return to IDLE (one bubble cycle before the next macro request loads).
- Latency: request accepted at cycle N into an idle block -> first reqValid at N+2.
- Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH. No wrap detection.
- reqOut payload stable while reqValid && !reqOut_grant.
- Response path, combinational, same cycle:
  - head = tag FIFO head.
  - respGrant = respValid && !tagQ_empty && !inbuf_full[head.pu].
  - inbuf_push[head.pu] = respGrant; all other bits 0.
  - On respGrant: pop tag FIFO.
- rd_done is registered: asserted the cycle after a respGrant whose head.last==1.
- respValid && tagQ_empty: set rd_err, assert respGrant to drain the response, push nothing.
- A PU whose buffer is full stalls all responses (in-order delivery). Issue continues until the tag FIFO is full.
- Simultaneous tag push (grant) and pop (response) in one cycle: occupancy unchanged; legal at full and at empty.
- AMI read responses return in request-issue order; the block does no reordering.

Test Plan:
- Single request: rd_addr=0x1000, size=4, pu=1, grant always, responses 3 cycles after grant. Expect:
  - reqOut.addr 0x1000, 0x1008, 0x1010, 0x1018 on 4 consecutive cycles from N+2.
  - 4 inbuf_push[1] pulses with matching data.
  - one rd_done, the cycle after the 4th push.
- Outstanding limit: size=20, no responses returned. Expect exactly 16 grants, then reqValid=0. Return 1 response -> reqValid reasserts the next cycle.
- Backpressure: two macros (pu0 size 2, pu1 size 2); hold inbuf_full[0]=1 for 5 cycles. Expect:
  - respGrant=0 and no pushes during the hold.
  - pushes to pu0, pu0, pu1, pu1 in order.
  - two rd_done pulses.
- Queue full: 9 back-to-back rd_req with reqOut_grant=0. Expect rd_ready low after 8 accepted; 9th not enqueued. Zero-size request produces no reqValid and no rd_done.
- Error and reset: respValid with nothing outstanding -> rd_err=1 and stays set. Assert rst_n=0 mid-ISSUE -> all outputs immediately at reset values and rd_err cleared.
